// File: rtl/icache_ctrl.sv
// rtl/icache_ctrl.sv - sequencing controller for a 2-way L1 instruction cache
//
// Purpose: takes one IF-stage fetch at a time, looks up both tag ways, returns
// the word on a hit, or refills the victim way from L2 on a miss and returns
// the word once the tag write has completed. Keeps saturating hit/miss counts.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   if_req/if_addr/if_flush  fetch request, byte address, cancel
//   if_busy                  controller not in IDLE
//   insn/insn_valid          registered instruction word and its one-cycle pulse
//   index                    set index to tag_ram/data_ram
//   tag0_rw/tag1_rw/tag_wd   per-way tag write strobes and write data
//   tag0_rd/tag1_rd          {valid, tag} of each way
//   LUR                      replacement way (0 -> way0, 1 -> way1)
//   complete                 tag write done, one cycle after the strobe
//   data0_rw/data1_rw/data_wd per-way line write strobes and write data
//   data0_rd/data1_rd        line read data of each way
//   l2_req/l2_addr           line request to L2, held until l2_ack
//   l2_ack/l2_data           L2 acknowledge pulse with the refill line
//   hit_cnt/miss_cnt         saturating performance counters

module icache_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [31:0]      if_addr,
  input  logic             if_flush,
  output logic             if_busy,
  output logic [31:0]      insn,
  output logic             insn_valid,
  output logic [7:0]       index,
  output logic             tag0_rw,
  output logic             tag1_rw,
  output logic [19:0]      tag_wd,
  input  logic [20:0]      tag0_rd,
  input  logic [20:0]      tag1_rd,
  input  logic             LUR,
  input  logic             complete,
  output logic             data0_rw,
  output logic             data1_rw,
  output logic [127:0]     data_wd,
  input  logic [127:0]     data0_rd,
  input  logic [127:0]     data1_rd,
  output logic             l2_req,
  output logic [27:0]      l2_addr,
  input  logic             l2_ack,
  input  logic [127:0]     l2_data,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOOKUP   = 3'd1;
  localparam logic [2:0] S_MISS     = 3'd2;
  localparam logic [2:0] S_FILL     = 3'd3;
  localparam logic [2:0] S_WAIT_CMP = 3'd4;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  logic [2:0]       state_q, state_d;
  logic [31:2]      addr_q, addr_d;
  logic             cancel_q, cancel_d;
  logic             victim_q, victim_d;
  logic [127:0]     line_q, line_d;
  logic [31:0]      insn_q, insn_d;
  logic             insn_valid_q, insn_valid_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  logic             hit0, hit1, fill;
  logic [6:0]       word_lsb;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^if_addr[1:0];

  assign hit0     = tag0_rd[20] & (tag0_rd[19:0] == addr_q[31:12]);
  assign hit1     = tag1_rd[20] & (tag1_rd[19:0] == addr_q[31:12]);
  assign word_lsb = {addr_q[3:2], 5'd0};
  assign fill     = (state_q == S_FILL);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cancel_d     = cancel_q;
    victim_d     = victim_q;
    line_d       = line_q;
    insn_d       = insn_q;
    insn_valid_d = 1'b0;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (if_req) begin
          addr_d   = if_addr[31:2];
          cancel_d = 1'b0;
          state_d  = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit0 | hit1) begin
          // way0 takes priority when both ways report a hit
          insn_d       = hit0 ? data0_rd[word_lsb +: 32] : data1_rd[word_lsb +: 32];
          insn_valid_d = ~if_flush;
          hit_cnt_d    = (&hit_cnt_q) ? hit_cnt_q : hit_cnt_q + CNT_W'(1);
          state_d      = S_IDLE;
        end else begin
          victim_d   = LUR;
          miss_cnt_d = (&miss_cnt_q) ? miss_cnt_q : miss_cnt_q + CNT_W'(1);
          cancel_d   = if_flush;
          state_d    = S_MISS;
        end
      end
      S_MISS: begin
        cancel_d = cancel_q | if_flush;
        if (l2_ack) begin
          line_d  = l2_data;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        cancel_d = cancel_q | if_flush;
        state_d  = S_WAIT_CMP;
      end
      S_WAIT_CMP: begin
        cancel_d = cancel_q | if_flush;
        if (complete) begin
          // a flush arriving in this very cycle still suppresses the pulse
          insn_d       = line_q[word_lsb +: 32];
          insn_valid_d = ~(cancel_q | if_flush);
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      cancel_q     <= 1'b0;
      victim_q     <= 1'b0;
      line_q       <= '0;
      insn_q       <= '0;
      insn_valid_q <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cancel_q     <= cancel_d;
      victim_q     <= victim_d;
      line_q       <= line_d;
      insn_q       <= insn_d;
      insn_valid_q <= insn_valid_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  // Strobes and write data derive from state only, so a reset returns them to
  // READ/zero in the following cycle and an abandoned refill never writes.
  assign if_busy    = (state_q != S_IDLE);
  assign index      = (state_q == S_IDLE) ? if_addr[11:4] : addr_q[11:4];
  assign tag0_rw    = (fill & ~victim_q) ? RW_WRITE : RW_READ;
  assign tag1_rw    = (fill &  victim_q) ? RW_WRITE : RW_READ;
  assign data0_rw   = (fill & ~victim_q) ? RW_WRITE : RW_READ;
  assign data1_rw   = (fill &  victim_q) ? RW_WRITE : RW_READ;
  assign tag_wd     = fill ? addr_q[31:12] : '0;
  assign data_wd    = fill ? line_q : '0;
  assign l2_req     = (state_q == S_MISS);
  assign l2_addr    = addr_q[31:4];
  assign insn       = insn_q;
  assign insn_valid = insn_valid_q;
  assign hit_cnt    = hit_cnt_q;
  assign miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_icache_ctrl.sv
// tb/tb_icache_ctrl.sv - randomized self-checking bench for icache_ctrl
//
// Purpose: models tag/data RAMs and L2 around the controller and checks every
// fetch against a set-level reference of which tag lives in which way.
// Ports: none (top-level bench).

module tb_icache_ctrl;

  localparam int CNT_W = 4;
  localparam int CMAX  = 15;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             if_req = 1'b0;
  logic [31:0]      if_addr = '0;
  logic             if_flush = 1'b0;
  logic             if_busy;
  logic [31:0]      insn;
  logic             insn_valid;
  logic [7:0]       index;
  logic             tag0_rw, tag1_rw;
  logic [19:0]      tag_wd;
  logic [20:0]      tag0_rd, tag1_rd;
  logic             LUR = 1'b0;
  logic             complete = 1'b0;
  logic             data0_rw, data1_rw;
  logic [127:0]     data_wd;
  logic [127:0]     data0_rd, data1_rd;
  logic             l2_req;
  logic [27:0]      l2_addr;
  logic             l2_ack = 1'b0;
  logic [127:0]     l2_data = '0;
  logic [CNT_W-1:0] hit_cnt, miss_cnt;

  int n_chk = 0;
  int n_err = 0;
  int n_hit = 0;
  int n_miss = 0;

  // RAM contents as written by the DUT
  bit           mv [2][256];
  logic [19:0]  mt [2][256];
  logic [127:0] md [2][256];

  // reference: which tag the bench expects in each way of each set
  bit           rv [2][256];
  logic [19:0]  rt [2][256];

  always #5 clk = ~clk;

  icache_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_busy(if_busy), .insn(insn), .insn_valid(insn_valid), .index(index),
    .tag0_rw(tag0_rw), .tag1_rw(tag1_rw), .tag_wd(tag_wd),
    .tag0_rd(tag0_rd), .tag1_rd(tag1_rd), .LUR(LUR), .complete(complete),
    .data0_rw(data0_rw), .data1_rw(data1_rw), .data_wd(data_wd),
    .data0_rd(data0_rd), .data1_rd(data1_rd),
    .l2_req(l2_req), .l2_addr(l2_addr), .l2_ack(l2_ack), .l2_data(l2_data),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  assign tag0_rd  = {mv[0][index], mt[0][index]};
  assign tag1_rd  = {mv[1][index], mt[1][index]};
  assign data0_rd = md[0][index];
  assign data1_rd = md[1][index];

  always @(posedge clk) begin
    if (tag0_rw)  begin mv[0][index] <= 1'b1; mt[0][index] <= tag_wd; end
    if (tag1_rw)  begin mv[1][index] <= 1'b1; mt[1][index] <= tag_wd; end
    if (data0_rw) md[0][index] <= data_wd;
    if (data1_rw) md[1][index] <= data_wd;
    complete <= tag0_rw | tag1_rw;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mw(input logic [27:0] la, input logic [1:0] w);
    return {la[21:0], 8'hA5, w};
  endfunction

  function automatic logic [127:0] line_of(input logic [27:0] la);
    return {mw(la, 2'd3), mw(la, 2'd2), mw(la, 2'd1), mw(la, 2'd0)};
  endfunction

  function automatic int sat(input int n);
    return (n > CMAX) ? CMAX : n;
  endfunction

  // fmode: 0 none, 1 flush during LOOKUP, 2 flush on first MISS cycle
  task automatic fetch(input logic [31:0] a, input logic lur, input int fmode, input int dly);
    logic [7:0]  ix;
    logic [19:0] tg;
    bit          h;
    ix = a[11:4];
    tg = a[31:12];
    h  = (rv[0][ix] && rt[0][ix] == tg) || (rv[1][ix] && rt[1][ix] == tg);
    if_req = 1'b1; if_addr = a;
    @(posedge clk); #1;
    if_req = 1'b0;
    chk("lookup_busy", if_busy, 1'b1);
    LUR = lur; if_flush = (fmode == 1);
    @(posedge clk); #1;
    if_flush = 1'b0;
    if (h) begin
      n_hit++;
      chk("hit_valid", insn_valid, fmode != 1);
      if (fmode != 1) chk("hit_insn", insn, mw(a[31:4], a[3:2]));
      chk("hit_l2req", l2_req, 1'b0);
      chk("hit_busy", if_busy, 1'b0);
      chk("hit_cnt", hit_cnt, sat(n_hit));
    end else begin
      n_miss++;
      chk("miss_l2req", l2_req, 1'b1);
      chk("miss_l2addr", l2_addr, a[31:4]);
      chk("miss_cnt", miss_cnt, sat(n_miss));
      if_flush = (fmode == 2);
      repeat (dly) begin
        @(posedge clk); #1;
        if_flush = 1'b0;
        chk("l2req_hold", l2_req, 1'b1);
      end
      l2_ack = 1'b1; l2_data = line_of(a[31:4]);
      @(posedge clk); #1;
      l2_ack = 1'b0; if_flush = 1'b0; l2_data = {4{$urandom()}};
      chk("fill_tag_rw", {tag1_rw, tag0_rw}, lur ? 2'b10 : 2'b01);
      chk("fill_data_rw", {data1_rw, data0_rw}, lur ? 2'b10 : 2'b01);
      chk("fill_tag_wd", tag_wd, tg);
      chk("fill_data_wd", data_wd, line_of(a[31:4]));
      @(posedge clk); #1;
      chk("wait_strobes", {tag1_rw, tag0_rw, data1_rw, data0_rw}, 4'b0);
      chk("wait_valid", insn_valid, 1'b0);
      @(posedge clk); #1;
      chk("miss_valid", insn_valid, fmode == 0);
      if (fmode == 0) chk("miss_insn", insn, mw(a[31:4], a[3:2]));
      chk("miss_busy", if_busy, 1'b0);
      rv[lur][ix] = 1'b1;
      rt[lur][ix] = tg;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, fm;
    logic [31:0] a;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_busy", if_busy, 1'b0);
    chk("rst_insn", insn, 32'h0);
    chk("rst_valid", insn_valid, 1'b0);
    chk("rst_l2req", l2_req, 1'b0);
    chk("rst_rw", {tag1_rw, tag0_rw, data1_rw, data0_rw}, 4'b0);
    chk("rst_wd", {tag_wd, data_wd}, '0);
    chk("rst_cnt", {hit_cnt, miss_cnt}, '0);

    fetch(32'h0000_1234, 1'b0, 0, 2);
    fetch(32'h0000_1234, 1'b1, 0, 0);
    fetch(32'h0000_2234, 1'b1, 0, 1);
    fetch(32'h0000_1238, 1'b0, 0, 0);
    fetch(32'h0000_2230, 1'b0, 0, 0);
    fetch(32'h0000_3234, 1'b0, 0, 3);
    fetch(32'h0000_2230, 1'b0, 0, 0);
    fetch(32'h0000_5560, 1'b0, 2, 1);
    fetch(32'h0000_5564, 1'b1, 0, 0);

    // reset while the L2 request is outstanding
    if_req = 1'b1; if_addr = 32'h0000_7770;
    @(posedge clk); #1;
    if_req = 1'b0; LUR = 1'b0;
    @(posedge clk); #1;
    chk("prerst_l2req", l2_req, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_l2req", l2_req, 1'b0);
    chk("midrst_busy", if_busy, 1'b0);
    chk("midrst_cnt", {hit_cnt, miss_cnt}, '0);
    repeat (3) begin
      chk("midrst_rw", {tag1_rw, tag0_rw, data1_rw, data0_rw}, 4'b0);
      @(posedge clk); #1;
    end
    n_hit = 0; n_miss = 0;
    fetch(32'h0000_7770, 1'b1, 0, 0);

    for (int i = 0; i < 150; i++) begin
      r  = $urandom_range(0, 7);
      fm = (r == 0) ? 1 : (r == 1) ? 2 : 0;
      a  = {18'h0, 2'($urandom_range(0, 3)), ($urandom_range(0, 1) != 0) ? 8'h23 : 8'h56,
            2'($urandom_range(0, 3)), 2'b00};
      fetch(a, 1'($urandom_range(0, 1)), fm, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/icache_ctrl.md
Name: icache_ctrl

Overview:
- Sequencing controller for the 2-way L1 instruction cache built from tag_ram and data_ram.
- Accepts one fetch request at a time from the IF stage and performs the tag lookup.
- On a hit, returns the selected 32-bit instruction word.
- On a miss, fetches the 128-bit line from L2, writes it into the replacement way (tag and data), waits for the tag write-complete, then returns the word.
- Keeps saturating hit and miss counters.

Parameters:
CNT_W, 16, width of the hit and miss performance counters (saturating)

Ports:
clk  in  1  clock; everything on rising edge
rst  in  1  synchronous, active-high reset
if_req  in  1  fetch request; sampled only in IDLE
if_addr  in  32  fetch byte address; tag=[31:12], index=[11:4], word=[3:2]
if_flush  in  1  cancel outstanding fetch (branch/exception)
if_busy  out  1  high in every state except IDLE
insn  out  32  returned instruction, registered
insn_valid  out  1  one-cycle pulse, insn valid
index  out  8  cache index to tag_ram/data_ram
tag0_rw  out  1  `WRITE strobe for way0 tag, else `READ
tag1_rw  out  1  `WRITE strobe for way1 tag, else `READ
tag_wd  out  20  tag write data
tag0_rd  in  21  {valid, tag} of way0 (combinational read)
tag1_rd  in  21  {valid, tag} of way1
LUR  in  1  replacement bit: 0 -> replace way0, 1 -> replace way1
complete  in  1  tag write done, one cycle after the write strobe
data0_rw  out  1  `WRITE strobe for way0 data
data1_rw  out  1  `WRITE strobe for way1 data
data_wd  out  128  line write data
data0_rd  in  128  way0 line
data1_rd  in  128  way1 line
l2_req  out  1  line request to L2, held until ack
l2_addr  out  28  line address, addr_q[31:4]
l2_ack  in  1  one-cycle pulse; l2_data valid in the same cycle
l2_data  in  128  refill line
hit_cnt  out  CNT_W  hits, saturating
miss_cnt  out  CNT_W  misses, saturating

Behaviour:
Reset:
- state=IDLE.
- insn=0, insn_valid=0, l2_req=0, all rw=`READ.
- tag_wd=0, data_wd=0, counters=0, cancel flag=0.

Reset mid-operation:
- Any in-flight L2 request is abandoned: l2_req is deasserted and no RAM write is issued.

index:
- if_addr[11:4] in IDLE; latched addr_q[11:4] in all other states.

States:
- IDLE: if_req=1 -> latch if_addr into addr_q, clear cancel, go to LOOKUP. if_flush is ignored in IDLE.
- LOOKUP (1 cycle):
  - hitN = tagN_rd[20] & (tagN_rd[19:0]==addr_q[31:12]). If both ways hit, way0 wins.
  - Hit: insn <= word addr_q[3:2] of the hit way's line (word0 = bits[31:0]), insn_valid pulses next cycle, hit_cnt++, go to IDLE.
  - Miss: victim <= LUR, miss_cnt++, go to MISS.
- MISS: l2_req=1, l2_addr=addr_q[31:4]. On l2_ack, capture l2_data into line_q and go to FILL.
- FILL (exactly 1 cycle):
  - tag_wd=addr_q[31:12], data_wd=line_q.
  - Assert tag{victim}_rw and data{victim}_rw = `WRITE; the other way stays `READ.
  - Go to WAIT_CMP.
- WAIT_CMP:
  - On complete=1: insn <= word addr_q[3:2] of line_q, and insn_valid pulses next cycle unless cancel=1. Go to IDLE.
  - While complete=0, remain in WAIT_CMP.

Latency:
- Hit: if_req sampled in cycle 0 -> insn_valid in cycle 2.
- Miss with l2_ack in cycle A: FILL at A+1, WAIT_CMP at A+2, insn_valid at A+3.
- Back-to-back: a new request can be accepted in the same cycle insn_valid is high (FSM is in IDLE).

Flush:
- if_flush in LOOKUP on a hit: insn_valid is suppressed; the hit is still counted.
- if_flush in LOOKUP on a miss, or in MISS, FILL or WAIT_CMP: cancel flag is set. The refill runs to completion (the L2 transaction is not abandoned) and the line is still written, but insn_valid is suppressed.

Counters:
- Increment by 1 and saturate at all-ones, no wrap.

Write strobes:
- Never asserted outside FILL.
- Never asserted for both ways at once.

Test Plan:
- Reset, then if_req addr=0x0000_1234 on a cold cache -> LOOKUP miss; l2_req=1 with l2_addr=0x0000123. Ack with data {W3,W2,W1,W0} two cycles later -> single FILL strobe tag0_rw/data0_rw (LUR=0), insn=W1, insn_valid exactly 3 cycles after ack, miss_cnt=1.
- Repeat addr 0x0000_1234 -> insn_valid 2 cycles after request, insn=W1, hit_cnt=1, l2_req stays 0.
- Miss on 0x0000_2234 (same index, other tag) -> way1 written since LUR=1. Then fetches to 0x1238 and 0x2230 both hit with correct words. A third tag 0x3234 replaces way0.
- Pulse if_flush during MISS -> refill still writes, no insn_valid pulse. A re-fetch of the same address then hits.
- Assert rst while l2_req=1 -> next cycle l2_req=0, if_busy=0, no write strobes, counters=0.
- Force hit_cnt to all-ones (CNT_W=4 build), then perform one more hit -> hit_cnt stays 15.
